series_ctrl: RTL
================

SERIES_CTRL -- requirements
Module: series_ctrl

Interface
REQ-001 SHALL have parameter MULT_STEPS, default 4, multiply cycles per series term (legal range 2..16).
REQ-002 SHALL have parameter MAX_TERMS, default 8, term cap (legal range 1..255); CNT_W = clog2(MAX_TERMS+1), SEL_W = clog2(MULT_STEPS).
REQ-003 SHALL have port clock, input, 1 bit; single clock, rising edge.
REQ-004 SHALL have port reset, input, 1 bit; asynchronous, active-high.
REQ-005 SHALL have ports start, compared, alt_mode and abort, each input, 1 bit: start request; datapath "term still significant" flag; alternate sign per term; cancel.
REQ-006 SHALL have ports load_x, init1_t, load_t, init1_r, load_r, init0_cnt and en_cnt, each output, 1 bit: datapath strobes.
REQ-007 SHALL have port sel, output, SEL_W bits, current multiply-step index.
REQ-008 SHALL have ports ci, ready, busy and done, each output, 1 bit: add/sub select (1 = add); idle; running; one-cycle completion pulse.
REQ-009 SHALL have port term_idx, output, CNT_W bits, count of terms accumulated.

Function
REQ-010 SHALL implement states IDLE, INIT, LOAD, MULT, COMPARE, ACCUM, DONE; every strobe defaults to 0 in every state.
REQ-011 IDLE: ready=1; go to INIT when start=1, else stay.
REQ-012 INIT: init1_t=1, init1_r=1, init0_cnt=1; clear term_idx and step; set ci=1; stay while start=1, else go to LOAD.
REQ-013 LOAD: load_x=1; go to MULT with step=0.
REQ-014 MULT: load_t=1 and sel=step every cycle; en_cnt=1 only when step=MULT_STEPS-1; step increments; after the last step go to COMPARE.
REQ-015 On entry to MULT step 0 with alt_mode=1, ci SHALL toggle (registered); with alt_mode=0, ci holds 1.
REQ-016 COMPARE: no strobes; term_idx increments.
REQ-017 COMPARE exit: if compared=0, or (limit enabled) the incremented term_idx equals MAX_TERMS, go to DONE; otherwise go to ACCUM.
REQ-018 ACCUM: load_r=1; go to MULT step 0.
REQ-019 DONE: done=1 for exactly one cycle; go to IDLE.
REQ-020 busy SHALL be 1 in every state except IDLE; ready and busy are never both 1.
REQ-021 abort=1 in any state other than IDLE SHALL force IDLE on the next edge with done=0, overriding every other transition; abort is ignored in IDLE.
REQ-022 start asserted while busy (outside INIT) SHALL be ignored.
REQ-023 Per-term latency SHALL be MULT_STEPS+2 cycles.

Reset
REQ-024 While reset=1: state IDLE, step=0, term_idx=0, ci=1; ready=1; every other output 0.
REQ-025 Reset asserted mid-run SHALL discard the run without a done pulse.

Configuration
REQ-026 Macro SERIES_CTRL_TERM_LIMIT_EN defined: the MAX_TERMS cap in REQ-017 is enforced.
REQ-027 Macro absent: only compared=0 ends a run, and term_idx wraps modulo 2^CNT_W.

Structure
REQ-028 Package series_ctrl_pkg SHALL hold the state enum and the constants SIGN_ADD=1 and SIGN_SUB=0.
REQ-029 The step and term counters SHALL be a sub-module series_step_cnt (clear, step enable, term enable).
REQ-030 The top level SHALL hold the FSM and the output decode.

Verification
REQ-031 Reset mid-MULT, then release -> ready=1, ci=1, term_idx=0, no done pulse.
REQ-032 MULT_STEPS=4, start held 3 cycles, compared=1,1,1,0 -> INIT lasts 3 cycles; 3 load_r pulses; done occurs 25 cycles after INIT exit; term_idx=4.
REQ-033 Same as REQ-032 with alt_mode=1 -> ci=0,1,0 during the three ACCUM cycles; alt_mode=0 -> ci=1 throughout.
REQ-034 Macro defined, MAX_TERMS=3, compared stuck at 1 -> done after the 3rd COMPARE with term_idx=3; macro absent -> run continues past the 3rd term.
REQ-035 abort in the 2nd cycle of MULT -> IDLE next cycle, done=0; a new start then reruns normally.
REQ-036 MULT_STEPS=2 -> sel sequence 0,1 and en_cnt only on step 1, each term.

Source files
------------

// File: rtl/series_ctrl_pkg.sv
// Shared types and constants for the series evaluation sequencer.
package series_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INIT    = 3'd1,
        LOAD    = 3'd2,
        MULT    = 3'd3,
        COMPARE = 3'd4,
        ACCUM   = 3'd5,
        DONE    = 3'd6
    } state_e;

    localparam logic SIGN_ADD = 1'b1;
    localparam logic SIGN_SUB = 1'b0;

endpackage

// File: rtl/series_step_cnt.sv
// Multiply-step index (wraps after the last step) and accumulated-term counter.
module series_step_cnt #(
    parameter int MULT_STEPS = 4,
    parameter int SEL_W      = 2,
    parameter int CNT_W      = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             step_en_i,
    input  logic             term_en_i,
    output logic [SEL_W-1:0] step_o,
    output logic [CNT_W-1:0] term_o,
    output logic             last_step_o
);

    logic [SEL_W-1:0] step_q, step_d;
    logic [CNT_W-1:0] term_q, term_d;

    assign last_step_o = (step_q == SEL_W'(MULT_STEPS - 1));
    assign step_o      = step_q;
    assign term_o      = term_q;

    // Next-state for both counters; clear has priority over the enables.
    always_comb begin
        step_d = step_q;
        term_d = term_q;
        if (clear_i) begin
            step_d = {SEL_W{1'b0}};
            term_d = {CNT_W{1'b0}};
        end else begin
            if (step_en_i) begin
                step_d = last_step_o ? {SEL_W{1'b0}} : step_q + SEL_W'(1);
            end else begin
                step_d = step_q;
            end
            if (term_en_i) begin
                term_d = term_q + CNT_W'(1);
            end else begin
                term_d = term_q;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            step_q <= {SEL_W{1'b0}};
            term_q <= {CNT_W{1'b0}};
        end else begin
            step_q <= step_d;
            term_q <= term_d;
        end
    end

endmodule

// File: rtl/series_ctrl.sv
// Sequencer for an iterative series evaluator: load, multiply, compare, accumulate per term.
// Define SERIES_CTRL_TERM_LIMIT_EN to end a run once MAX_TERMS terms have been accumulated.
module series_ctrl
    import series_ctrl_pkg::*;
#(
    parameter int  MULT_STEPS = 4,
    parameter int  MAX_TERMS  = 8,
    localparam int CNT_W      = $clog2(MAX_TERMS + 1),
    localparam int SEL_W      = $clog2(MULT_STEPS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             compared,
    input  logic             alt_mode,
    input  logic             abort,
    output logic             load_x,
    output logic             init1_t,
    output logic             load_t,
    output logic             init1_r,
    output logic             load_r,
    output logic             init0_cnt,
    output logic             en_cnt,
    output logic [SEL_W-1:0] sel,
    output logic             ci,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] term_idx
);

    state_e           state_q, state_d;
    logic             ci_q, ci_d;
    logic             cnt_clear_s, step_en_s, term_en_s;
    logic             last_step_s, limit_hit_s;
    logic [SEL_W-1:0] step_s;
    logic [CNT_W-1:0] term_s;

    series_step_cnt #(
        .MULT_STEPS(MULT_STEPS),
        .SEL_W     (SEL_W),
        .CNT_W     (CNT_W)
    ) u_cnt (
        .clock      (clock),
        .reset      (reset),
        .clear_i    (cnt_clear_s),
        .step_en_i  (step_en_s),
        .term_en_i  (term_en_s),
        .step_o     (step_s),
        .term_o     (term_s),
        .last_step_o(last_step_s)
    );

`ifdef SERIES_CTRL_TERM_LIMIT_EN
    assign limit_hit_s = ((term_s + CNT_W'(1)) == CNT_W'(MAX_TERMS));
`else
    assign limit_hit_s = 1'b0;
`endif

    assign term_idx = term_s;
    assign ci       = ci_q;
    assign ready    = (state_q == IDLE);
    assign busy     = (state_q != IDLE);

    // Next-state, sign update and strobe decode.
    always_comb begin
        state_d     = state_q;
        ci_d        = ci_q;
        cnt_clear_s = 1'b0;
        step_en_s   = 1'b0;
        term_en_s   = 1'b0;
        load_x      = 1'b0;
        init1_t     = 1'b0;
        load_t      = 1'b0;
        init1_r     = 1'b0;
        load_r      = 1'b0;
        init0_cnt   = 1'b0;
        en_cnt      = 1'b0;
        done        = 1'b0;
        sel         = {SEL_W{1'b0}};
        case (state_q)
            IDLE: begin
                state_d = start ? INIT : IDLE;
            end
            INIT: begin
                init1_t     = 1'b1;
                init1_r     = 1'b1;
                init0_cnt   = 1'b1;
                cnt_clear_s = 1'b1;
                ci_d        = SIGN_ADD;
                state_d     = start ? INIT : LOAD;
            end
            LOAD: begin
                load_x  = 1'b1;
                state_d = MULT;
            end
            MULT: begin
                load_t    = 1'b1;
                sel       = step_s;
                step_en_s = 1'b1;
                en_cnt    = last_step_s;
                state_d   = last_step_s ? COMPARE : MULT;
                // The sign flips once per term, on the first multiply step.
                if ((step_s == {SEL_W{1'b0}}) && alt_mode) begin
                    ci_d = ~ci_q;
                end else begin
                    ci_d = ci_q;
                end
            end
            COMPARE: begin
                term_en_s = 1'b1;
                state_d   = (!compared || limit_hit_s) ? DONE : ACCUM;
            end
            ACCUM: begin
                load_r  = 1'b1;
                state_d = MULT;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
        end else begin
            state_d = state_d;
        end
    end

    // State and sign registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ci_q    <= SIGN_ADD;
        end else begin
            state_q <= state_d;
            ci_q    <= ci_d;
        end
    end

endmodule
